// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// state enum, opcode constants and datapath mux/ALU select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMX4 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_out_dec.sv
// Moore output decode: state encoding -> datapath control word.
// Ports: state (4b in); IorD..PCSrc control outputs. ADDI states need MIPS_FSM_ADDI_EN.
module mips_ctrl_out_dec
  import mips_pkg::*;
(
  input  logic [3:0] state,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc
);

  always_comb begin
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_WD;
    ALUOp    = ALUOP_ADD;
    PCSrc    = PCSRC_ALU;
    case (state)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMMX4;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        IorD = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BEQEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        Branch  = 1'b1;
        PCSrc   = PCSRC_ALUOUT;
      end
`ifdef MIPS_FSM_ADDI_EN
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
`endif
      JEX: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic, output decode.
// Ports: clk, reset (async high), Op[5:0]; control outputs; state_o. ADDI via MIPS_FSM_ADDI_EN.
module mips_ctrl_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] state_o
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_RTYPE: state_d = RTYPEEX;
          OP_BEQ:   state_d = BEQEX;
`ifdef MIPS_FSM_ADDI_EN
          OP_ADDI:  state_d = ADDIEX;
`endif
          OP_J:     state_d = JEX;
          default:  state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
`ifdef MIPS_FSM_ADDI_EN
      ADDIEX:  state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase
  end

  assign state_o = state_q;

  mips_ctrl_out_dec u_dec (
    .state    (state_q),
    .IorD     (IorD),
    .IRWrite  (IRWrite),
    .MemWrite (MemWrite),
    .PCWrite  (PCWrite),
    .Branch   (Branch),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSrc    (PCSrc)
  );

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from the shared package.
REQ-002 The port list SHALL be as follows:
  clk       in   1  sole clock, rising edge
  reset     in   1  asynchronous, active-high
  Op        in   6  instruction opcode field, IR[31:26]
  IorD      out  1  memory address select: 0 = PC, 1 = ALUOut
  IRWrite   out  1  instruction register load
  MemWrite  out  1  data memory write strobe
  PCWrite   out  1  unconditional PC load
  Branch    out  1  conditional PC load, qualified externally by Zero
  RegWrite  out  1  register file write strobe
  RegDst    out  1  write register select: 0 = rt, 1 = rd
  MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
  ALUSrcA   out  1  ALU A select: 0 = PC, 1 = register A
  ALUSrcB   out  2  ALU B select: 00 = WriteData, 01 = constant 4, 10 = Imm, 11 = Immx4
  ALUOp     out  2  00 = add, 01 = sub, 10 = funct-decoded
  PCSrc     out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
  state_o   out  4  current state encoding, for debug

Function
REQ-003 The block SHALL be a Moore FSM; every output SHALL be a pure combinational function of the state register only.
REQ-004 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-005 Opcodes SHALL be: LW = 100011, SW = 101011, RTYPE = 000000, BEQ = 000100, ADDI = 001000, J = 000010.
REQ-006 Transitions SHALL be: FETCH -> DECODE, always.
REQ-007 DECODE SHALL go to MEMADR for LW/SW, RTYPEEX for RTYPE, BEQEX for BEQ, ADDIEX for ADDI, JEX for J, and FETCH for any other opcode.
REQ-008 MEMADR SHALL go to MEMRD if Op = LW, otherwise to MEMWR.
REQ-009 The remaining transitions SHALL be: MEMRD -> MEMWB; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
REQ-010 Any unused state encoding SHALL go to FETCH on the next clk edge.
REQ-011 All outputs not listed for a state SHALL be 0.
REQ-012 Per-state outputs SHALL be as follows:
  FETCH:   IRWrite = 1, PCWrite = 1, ALUSrcB = 01, IorD = 0, ALUSrcA = 0, ALUOp = 00, PCSrc = 00
  DECODE:  ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00
  MEMADR:  ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00
  MEMRD:   IorD = 1
  MEMWB:   RegWrite = 1, MemtoReg = 1, RegDst = 0
  MEMWR:   IorD = 1, MemWrite = 1
  RTYPEEX: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10
  RTYPEWB: RegWrite = 1, RegDst = 1, MemtoReg = 0
  BEQEX:   ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, Branch = 1, PCSrc = 01
  ADDIEX:  ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00
  ADDIWB:  RegWrite = 1, RegDst = 0, MemtoReg = 0
  JEX:     PCWrite = 1, PCSrc = 10
REQ-013 Instruction latency in cycles SHALL be: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal opcode 2.
REQ-014 Op SHALL be sampled only in DECODE and MEMADR; Op changes in other states SHALL have no effect.
REQ-015 At most one of PCWrite/Branch, and at most one of MemWrite/RegWrite, SHALL be 1 in any state.

Reset
REQ-016 Asserting reset SHALL force the state to FETCH immediately, without waiting for clk, including mid-instruction.
REQ-017 While reset is high, outputs SHALL equal the FETCH values of REQ-012, so IRWrite = 1 and PCWrite = 1 during reset; the datapath registers SHALL hold under their own reset.
REQ-018 The first rising clk edge after reset deasserts SHALL move the state to DECODE.

Configuration
REQ-019 With macro MIPS_FSM_ADDI_EN defined, the ADDIEX/ADDIWB states and the ADDI decode SHALL exist as specified.
REQ-020 Without MIPS_FSM_ADDI_EN, ADDI SHALL be treated as an illegal opcode (DECODE -> FETCH), and the ADDI states SHALL not be synthesized.

Structure
REQ-021 Package mips_pkg SHALL hold the state enum, the opcode constants, and the ALUSrcB, ALUOp and PCSrc encoding constants.
REQ-022 The next-state logic and the state register SHALL reside in mips_ctrl_fsm.
REQ-023 The state-to-control-word decode SHALL be the single sub-module mips_ctrl_out_dec (state in, outputs out).

Verification
REQ-024 Reset, release, Op = 100011: the state sequence SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; MemtoReg = 1 and RegWrite = 1 only in cycle 5.
REQ-025 Op = 101011: MemWrite = 1 and IorD = 1 SHALL occur in cycle 4 only; RegWrite SHALL stay 0; the FSM SHALL return to FETCH in cycle 5.
REQ-026 Op = 000000 then 000100: ALUSrcB SHALL read 01, 11, 00, xx for RTYPE; BEQEX SHALL show ALUOp = 01, Branch = 1, PCSrc = 01.
REQ-027 Op = 111111 in DECODE SHALL give a return to FETCH after 2 cycles with no write strobes; Op = 001000 with the macro undefined SHALL behave identically.
REQ-028 Reset asserted asynchronously in MEMRD SHALL make state_o equal to the FETCH encoding before the next clk edge, with IRWrite = 1.
